// File: rtl/dmem_pkg.sv
// Shared types for the data-memory bus controller: FSM states, bus widths and the latched request.
// Imported by dmem_bus_ctrl and dmem_timeout_ctr.
package dmem_pkg;

    localparam int DMEM_DW = 32;
    localparam int DMEM_MW = DMEM_DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } dmem_state_e;

    typedef struct packed {
        logic               we;
        logic [DMEM_MW-1:0] mask;
        logic [DMEM_DW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Saturating transaction-age counter; expire_o flags the TimeoutCycles-th enabled cycle since clear.
// Single-cycle combinational expire; no backpressure.
module dmem_timeout_ctr
    import dmem_pkg::*;
#(
    parameter int TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TimeoutCycles + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CW'(TimeoutCycles))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Counter reads k-1 in the k-th enabled cycle, so this fires on cycle TimeoutCycles.
    assign expire_o = en_i && (cnt_q >= CW'(TimeoutCycles - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: latches a memory-stage access, runs a valid/ready bus transaction, pulses data_valid.
// Min 3 cycles per access; stalls the pipeline while in flight. DMEM_TIMEOUT_EN adds an abandon-on-timeout counter.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int DataWidth     = DMEM_DW,
    parameter int MaskWidth     = DMEM_MW,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [MaskWidth-1:0] mask,
    input  logic [DataWidth-1:0] addr,
    input  logic [DataWidth-1:0] store_data,
    output logic                 stall,
    output logic                 data_valid,
    output logic [DataWidth-1:0] load_data,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [MaskWidth-1:0] mem_mask,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 timeout_err
);

    dmem_state_e          state_q;
    dmem_req_t            req_q;
    logic [DataWidth-1:0] load_data_q;
    logic                 data_valid_q;
    logic                 mem_valid_q;
    logic                 in_flight;
    logic                 finish_ok;
    logic                 timed_out;
    logic                 expire;

    assign in_flight = (state_q == REQ) || (state_q == WAIT_RSP);
    assign finish_ok = ((state_q == REQ) && mem_ready && (req_q.we || mem_rvalid)) ||
                       ((state_q == WAIT_RSP) && mem_rvalid);
    // A real completion in the limit cycle beats the timeout.
    assign timed_out = expire && !finish_ok;

`ifdef DMEM_TIMEOUT_EN
    logic timeout_err_q;

    dmem_timeout_ctr #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout_ctr (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   ((state_q == IDLE) && request),
        .en_i    (in_flight),
        .expire_o(expire)
    );

    assign timeout_err = timeout_err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            load_data_q  <= '0;
            data_valid_q <= 1'b0;
            mem_valid_q  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (request) begin
                        req_q       <= '{we: we_re, mask: mask, addr: addr, wdata: store_data};
                        mem_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ, WAIT_RSP: begin
                    if (finish_ok || timed_out) begin
                        mem_valid_q  <= 1'b0;
                        data_valid_q <= 1'b1;
                        state_q      <= DONE;
                        if (timed_out) begin
                            load_data_q <= '0;
                        end else if (!req_q.we) begin
                            load_data_q <= mem_rdata;
                        end
                    end else if ((state_q == REQ) && mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= WAIT_RSP;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef DMEM_TIMEOUT_EN
            timeout_err_q <= timed_out;
`endif
        end
    end

    assign stall      = in_flight || ((state_q == IDLE) && request);
    assign data_valid = data_valid_q;
    assign load_data  = load_data_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = req_q.we;
    assign mem_mask   = req_q.mask;
    assign mem_addr   = req_q.addr & ~DataWidth'(3);
    assign mem_wdata  = req_q.wdata;

endmodule
